// File: rtl/rhd_frame_packetizer.sv
// rhd_frame_packetizer: packs RHD channel words into MAGIC-headed frames and batches frames into AXIS packets.
// Latency: the first magic beat is valid one cycle after the commit that completes a frame.
// Backpressure: the sample input is never stalled; whole frames are dropped when the FIFO lacks room.
// Optional: define RHD_PKT_TIMESTAMP_EN to insert a per-frame sequence word after the magic (frames become NUM_CH+3 words).
module rhd_frame_packetizer #(
  parameter int          NUM_CH     = 32,
  parameter int          FIFO_DEPTH = 128,
  parameter logic [63:0] MAGIC      = 64'hC691199927021942
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        enable,
  input  logic [7:0]  batch_size,
  input  logic [31:0] s_sample_data,
  input  logic        s_sample_valid,
  input  logic        s_sample_first,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        overflow,
  output logic        sync_err,
  output logic [15:0] dropped_frames,
  output logic [31:0] frame_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(NUM_CH);
  localparam logic [PW-1:0] C_NCH       = PW'(NUM_CH);
  localparam logic [PW-1:0] C_ADMIT_MAX = PW'(FIFO_DEPTH - NUM_CH);
  localparam logic [CW-1:0] C_LAST_CH   = CW'(NUM_CH - 1);
  localparam logic [CW-1:0] C_PENULT_CH = CW'(NUM_CH - 2);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MAGIC_LO  = 3'd1;
  localparam logic [2:0] S_MAGIC_HI  = 3'd2;
  localparam logic [2:0] S_DATA      = 3'd3;
  localparam logic [2:0] S_HOLD_LAST = 3'd4;
`ifdef RHD_PKT_TIMESTAMP_EN
  localparam logic [2:0] S_TSTAMP    = 3'd5;
  // One timestamp slot per frame that can fit in the sample FIFO.
  localparam int TS_DEPTH = FIFO_DEPTH / NUM_CH;
  localparam int TW       = $clog2(TS_DEPTH);
  localparam logic [TW:0] C_TS_FULL = (TW+1)'(TS_DEPTH);

  logic [31:0] r_ts_mem [TS_DEPTH];
  logic [TW:0] r_ts_wr;
  logic [TW:0] r_ts_rd;
`endif

  // Sample storage and pointers; the reader only ever sees words below r_cm.
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_cm;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_idx;
  logic          r_open;

  logic          r_overflow;
  logic          r_sync_err;
  logic [15:0]   r_dropped;
  logic [31:0]   r_frame_count;

  logic [2:0]    r_state;
  logic [CW-1:0] r_ch;
  logic [7:0]    r_batch;
  logic [7:0]    r_fip;
  logic [31:0]   r_hold_dat;
  logic          r_hold_vld;
  logic          r_hold_last;

  logic [PW-1:0] w_used;
  logic          w_frame_rdy;
  logic          w_first;
  logic          w_space_ok;
  logic          w_start;
  logic          w_reject;
  logic          w_cont;
  logic          w_commit;
  logic [AW-1:0] w_wr_addr;
  logic [AW-1:0] w_rd_nxt_addr;
  logic          w_last_frame;
  logic [31:0]   w_tdata;
  logic          w_tvalid;
  logic          w_tlast;

  assign w_used        = r_cm - r_rd;
  assign w_frame_rdy   = (w_used >= C_NCH);
  assign w_first       = s_sample_valid & s_sample_first;
`ifdef RHD_PKT_TIMESTAMP_EN
  assign w_space_ok    = (w_used <= C_ADMIT_MAX) && ((r_ts_wr - r_ts_rd) != C_TS_FULL);
`else
  assign w_space_ok    = (w_used <= C_ADMIT_MAX);
`endif
  // A first always restarts at the commit pointer, so space is measured from there.
  assign w_start       = w_first & enable & w_space_ok;
  assign w_reject      = w_first & enable & ~w_space_ok;
  assign w_cont        = s_sample_valid & ~s_sample_first & r_open & enable;
  assign w_commit      = w_cont & (r_idx == C_LAST_CH);
  assign w_wr_addr     = w_start ? r_cm[AW-1:0] : r_wr[AW-1:0];
  assign w_rd_nxt_addr = r_rd[AW-1:0] + AW'(1);
  assign w_last_frame  = (r_fip == (r_batch - 8'd1));

  // Sample RAM write port; no reset needed since pointers gate visibility.
  always_ff @(posedge aclk) begin
    if (w_start || w_cont) begin
      r_mem[w_wr_addr] <= s_sample_data;
    end
  end

`ifdef RHD_PKT_TIMESTAMP_EN
  // Sequence number of each frame, captured as it commits.
  always_ff @(posedge aclk) begin
    if (w_commit) begin
      r_ts_mem[r_ts_wr[TW-1:0]] <= r_frame_count;
    end
  end
`endif

  // Input side: open, fill, commit or rewind frames; keep sticky status and counters.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_wr          <= '0;
      r_cm          <= '0;
      r_idx         <= '0;
      r_open        <= 1'b0;
      r_overflow    <= 1'b0;
      r_sync_err    <= 1'b0;
      r_dropped     <= '0;
      r_frame_count <= '0;
`ifdef RHD_PKT_TIMESTAMP_EN
      r_ts_wr       <= '0;
`endif
    end else begin
      if (w_start) begin
        r_wr   <= r_cm + PW'(1);
        r_idx  <= CW'(1);
        r_open <= 1'b1;
      end else if (w_cont) begin
        r_wr <= r_wr + PW'(1);
        if (w_commit) begin
          r_cm          <= r_wr + PW'(1);
          r_open        <= 1'b0;
          r_frame_count <= r_frame_count + 32'd1;
`ifdef RHD_PKT_TIMESTAMP_EN
          r_ts_wr       <= r_ts_wr + (TW+1)'(1);
`endif
        end else begin
          r_idx <= r_idx + CW'(1);
        end
      end else if (r_open && (!enable || w_first)) begin
        // Abandon the partial frame: session stopped, or a rejected restart.
        r_wr   <= r_cm;
        r_open <= 1'b0;
      end
      if (w_first && enable && r_open) begin
        r_sync_err <= 1'b1;
      end
      if (w_reject) begin
        r_overflow <= 1'b1;
        if (r_dropped != 16'hFFFF) begin
          r_dropped <= r_dropped + 16'd1;
        end
      end
    end
  end

  // Output FSM: magic, optional timestamp, channel words, then packet continuation decision.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state     <= S_IDLE;
      r_rd        <= '0;
      r_ch        <= '0;
      r_batch     <= 8'd1;
      r_fip       <= '0;
      r_hold_dat  <= '0;
      r_hold_vld  <= 1'b0;
      r_hold_last <= 1'b0;
`ifdef RHD_PKT_TIMESTAMP_EN
      r_ts_rd     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_frame_rdy) begin
            r_state <= S_MAGIC_LO;
            r_batch <= (batch_size == 8'd0) ? 8'd1 : batch_size;
            r_fip   <= '0;
          end
        end
        S_MAGIC_LO: begin
          if (m_axis_tready) begin
            r_state <= S_MAGIC_HI;
          end
        end
        S_MAGIC_HI: begin
          if (m_axis_tready) begin
`ifdef RHD_PKT_TIMESTAMP_EN
            r_state <= S_TSTAMP;
`else
            r_state <= S_DATA;
`endif
            r_ch <= '0;
          end
        end
`ifdef RHD_PKT_TIMESTAMP_EN
        S_TSTAMP: begin
          if (m_axis_tready) begin
            r_ts_rd <= r_ts_rd + (TW+1)'(1);
            r_state <= S_DATA;
          end
        end
`endif
        S_DATA: begin
          if (m_axis_tready) begin
            if (r_ch == C_LAST_CH) begin
              r_rd    <= r_rd + PW'(1);
              r_state <= S_IDLE;
            end else if ((r_ch == C_PENULT_CH) && !w_last_frame) begin
              // Park the last channel word so its tlast can be decided later.
              r_rd        <= r_rd + PW'(2);
              r_hold_dat  <= r_mem[w_rd_nxt_addr];
              r_hold_vld  <= 1'b0;
              r_hold_last <= 1'b0;
              r_state     <= S_HOLD_LAST;
            end else begin
              r_rd <= r_rd + PW'(1);
              r_ch <= r_ch + CW'(1);
            end
          end
        end
        S_HOLD_LAST: begin
          if (!r_hold_vld) begin
            if (w_frame_rdy) begin
              r_hold_vld  <= 1'b1;
              r_hold_last <= 1'b0;
            end else if (!enable) begin
              r_hold_vld  <= 1'b1;
              r_hold_last <= 1'b1;
            end
          end else if (m_axis_tready) begin
            r_hold_vld <= 1'b0;
            if (r_hold_last) begin
              r_state <= S_IDLE;
            end else begin
              r_state <= S_MAGIC_LO;
              r_fip   <= r_fip + 8'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Beat presented to the stream, derived purely from FSM state so it holds under stall.
  always_comb begin
    w_tvalid = 1'b0;
    w_tdata  = '0;
    w_tlast  = 1'b0;
    case (r_state)
      S_MAGIC_LO: begin
        w_tvalid = 1'b1;
        w_tdata  = MAGIC[31:0];
      end
      S_MAGIC_HI: begin
        w_tvalid = 1'b1;
        w_tdata  = MAGIC[63:32];
      end
`ifdef RHD_PKT_TIMESTAMP_EN
      S_TSTAMP: begin
        w_tvalid = 1'b1;
        w_tdata  = r_ts_mem[r_ts_rd[TW-1:0]];
      end
`endif
      S_DATA: begin
        w_tvalid = 1'b1;
        w_tdata  = r_mem[r_rd[AW-1:0]];
        w_tlast  = (r_ch == C_LAST_CH);
      end
      S_HOLD_LAST: begin
        w_tvalid = r_hold_vld;
        w_tdata  = r_hold_dat;
        w_tlast  = r_hold_last;
      end
      default: begin
        w_tvalid = 1'b0;
      end
    endcase
  end

  assign m_axis_tdata   = w_tdata;
  assign m_axis_tvalid  = w_tvalid;
  assign m_axis_tlast   = w_tlast;
  assign overflow       = r_overflow;
  assign sync_err       = r_sync_err;
  assign dropped_frames = r_dropped;
  assign frame_count    = r_frame_count;

endmodule
